byte_adder_reg: RTL and testbench

- Registered 8-bit unsigned/two's-complement adder.
- Produces sum, carry-out and status flags (zero, signed overflow, half-carry) one clock after a valid input strobe.
- Used as the arithmetic leaf for datapath/ALU blocks that need a byte add with flag outputs on a clean register boundary.

---
 rtl/byte_adder_pkg.sv | 25 ++
 rtl/full_adder.sv | 13 +
 rtl/byte_adder_reg.sv | 88 ++++++++
 tb/tb_byte_adder_reg.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/byte_adder_pkg.sv
// Shared constants and result types for the registered byte adder.
package byte_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH  = 8;
   localparam int unsigned HALF_CARRY_BIT = 3;

   typedef struct packed {
      logic c;
      logic z;
      logic v;
      logic h;
   } flags_t;

   typedef struct packed {
      logic [DEFAULT_WIDTH-1:0] r;
      logic                     c;
      logic                     z;
      logic                     v;
      logic                     h;
   } result_t;

   localparam flags_t  FLAGS_RST  = '0;
   localparam result_t RESULT_RST = '0;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as a stage of the ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/byte_adder_reg.sv
// Registered ripple adder with carry/zero/overflow/half-carry flags, 1-cycle latency.
// Optional subtract mode (i_sub) enabled by defining BYTE_ADDER_SUB_EN.
module byte_adder_reg #(
   parameter int unsigned WIDTH = byte_adder_pkg::DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
`ifdef BYTE_ADDER_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_valid,
   output logic [WIDTH-1:0] o_r,
   output logic             o_c,
   output logic             o_z,
   output logic             o_v,
   output logic             o_h
);

   import byte_adder_pkg::*;

   localparam int unsigned MSB = WIDTH - 1;

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;
   flags_t           flags_n;

   logic             valid_q;
   logic [WIDTH-1:0] r_q;
   flags_t           flags_q;

   // Subtract is a + ~b + 1 on the same chain; carry-out then means "no borrow".
`ifdef BYTE_ADDER_SUB_EN
   assign b_eff   = i_sub ? ~i_b : i_b;
   assign cin_eff = i_sub ? 1'b1 : i_cin;
`else
   assign b_eff   = i_b;
   assign cin_eff = i_cin;
`endif

   assign carry[0] = cin_eff;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder u_fa (
         .a    (i_a[i]),
         .b    (b_eff[i]),
         .cin  (carry[i]),
         .s    (sum[i]),
         .cout (carry[i+1])
      );
   end

   always_comb begin
      flags_n   = FLAGS_RST;
      flags_n.c = carry[WIDTH];
      flags_n.z = (sum == '0);
      flags_n.v = (i_a[MSB] == b_eff[MSB]) && (sum[MSB] != i_a[MSB]);
      flags_n.h = carry[HALF_CARRY_BIT+1];
   end

   // Result/flags load only on valid; otherwise they hold while o_valid drops.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         r_q     <= '0;
         flags_q <= FLAGS_RST;
      end else begin
         valid_q <= i_valid;
         if (i_valid) begin
            r_q     <= sum;
            flags_q <= flags_n;
         end
      end
   end

   assign o_valid = valid_q;
   assign o_r     = r_q;
   assign o_c     = flags_q.c;
   assign o_z     = flags_q.z;
   assign o_v     = flags_q.v;
   assign o_h     = flags_q.h;

endmodule

// File: tb/tb_byte_adder_reg.sv
// Directed self-checking bench for byte_adder_reg (subtract cases under BYTE_ADDER_SUB_EN).
module tb_byte_adder_reg;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_valid;
   logic [7:0] i_a;
   logic [7:0] i_b;
   logic       i_cin;
`ifdef BYTE_ADDER_SUB_EN
   logic       i_sub;
`endif
   logic       o_valid;
   logic [7:0] o_r;
   logic       o_c;
   logic       o_z;
   logic       o_v;
   logic       o_h;

   int errors = 0;
   int checks = 0;

   byte_adder_reg dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .i_a     (i_a),
      .i_b     (i_b),
      .i_cin   (i_cin),
`ifdef BYTE_ADDER_SUB_EN
      .i_sub   (i_sub),
`endif
      .o_valid (o_valid),
      .o_r     (o_r),
      .o_c     (o_c),
      .o_z     (o_z),
      .o_v     (o_v),
      .o_h     (o_h)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] r,
                          input logic c, input logic z, input logic ov, input logic h);
      chk({tag, ".valid"}, 32'(o_valid), 32'(v));
      chk({tag, ".r"},     32'(o_r),     32'(r));
      chk({tag, ".c"},     32'(o_c),     32'(c));
      chk({tag, ".z"},     32'(o_z),     32'(z));
      chk({tag, ".v"},     32'(o_v),     32'(ov));
      chk({tag, ".h"},     32'(o_h),     32'(h));
   endtask

   // Drive at the falling edge, sample 1 time unit after the next rising edge.
   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic cin);
      @(negedge i_clk);
      i_valid = v;
      i_a     = a;
      i_b     = b;
      i_cin   = cin;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_a     = 8'h00;
      i_b     = 8'h00;
      i_cin   = 1'b0;
`ifdef BYTE_ADDER_SUB_EN
      i_sub   = 1'b0;
`endif
      #1;
      chk_out("reset0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Load a nonzero result, then reset mid-cycle with valid operands present.
      drive(1'b1, 8'hFF, 8'hFF, 1'b0);
      chk_out("pre_rst", 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
      #2;
      i_rst = 1'b1;
      #1;
      chk_out("rst_async", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge i_clk);
      #1;
      chk_out("rst_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge i_clk);
      i_rst   = 1'b0;
      i_valid = 1'b0;
      @(posedge i_clk);
      #1;
      chk_out("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      drive(1'b1, 8'hAA, 8'h55, 1'b0);
      chk_out("aa_55", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h12, 8'h23, 1'b0);
      chk_out("12_23", 1'b1, 8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'hFF, 8'h01, 1'b0);
      chk_out("ff_01", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 8'h00, 8'h00, 1'b0);
      chk_out("00_00", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 8'h80, 8'hC4, 1'b0);
      chk_out("80_c4", 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 8'hFF, 8'hFF, 1'b0);
      chk_out("ff_ff", 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'h7F, 8'h01, 1'b0);
      chk_out("7f_01", 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 8'hFF, 8'h00, 1'b1);
      chk_out("ff_00_cin", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);

      // Handshake: idle, three back-to-back pairs, then idle with held result.
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      chk_out("idle0", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 8'h01, 8'h02, 1'b0);
      chk_out("b2b_1", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h0F, 8'h01, 1'b0);
      chk_out("b2b_2", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 8'h40, 8'h40, 1'b0);
      chk_out("b2b_3", 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 8'hFF, 8'hFF, 1'b1);
      chk_out("hold_1", 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 8'h11, 8'h22, 1'b0);
      chk_out("hold_2", 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef BYTE_ADDER_SUB_EN
      @(negedge i_clk);
      i_sub = 1'b1;
      drive(1'b1, 8'h12, 8'h23, 1'b0);
      chk("sub_12_23.r", 32'(o_r), 32'h0000_00EF);
      chk("sub_12_23.c", 32'(o_c), 32'h0);
      drive(1'b1, 8'h23, 8'h12, 1'b1);
      chk("sub_23_12.r", 32'(o_r), 32'h0000_0011);
      chk("sub_23_12.c", 32'(o_c), 32'h1);
      drive(1'b1, 8'h80, 8'h01, 1'b0);
      chk("sub_80_01.r", 32'(o_r), 32'h0000_007F);
      chk("sub_80_01.v", 32'(o_v), 32'h1);
      @(negedge i_clk);
      i_sub = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
